// File: rtl/alu_mc_pkg.sv
// Shared op-code and FSM state definitions for the multi-cycle ALU.
// ALU_MC_MUL_EN adds the MUL state; without it op 10 decodes as illegal.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
`ifdef ALU_MC_MUL_EN
    , S_MUL = 2'd3
`endif
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle datapath: arithmetic, logic and compare ops.
// hit_o flags that op_i is one of the ops handled here.
module alu_mc_comb
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             hit_o
);

  always_comb begin
    res_o = '0;
    hit_o = 1'b1;
    case (op_e'(op_i))
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SLT:  res_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLTU: res_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU top: FSM, bit-serial shifter, optional shift-add multiplier.
// Define ALU_MC_MUL_EN to enable op 10 (MUL); otherwise op 10 is illegal.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  // One extra bit so the counter can hold WIDTH for the multiplier
  localparam int CNT_W = SHAMT_W + 1;

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] result_q;
  logic             illegal_q, out_valid_q;

  logic [WIDTH-1:0]   comb_res;
  logic               comb_hit;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = b[SHAMT_W-1:0];

  alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i   (a),
    .b_i   (b),
    .op_i  (op),
    .res_o (comb_res),
    .hit_o (comb_hit)
  );

  always_comb begin
    sh_d = sh_q;
    case (op_q)
      OP_SLL:  sh_d = {sh_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_d = {1'b0, sh_q[WIDTH-1:1]};
      OP_SRA:  sh_d = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      default: sh_d = sh_q;
    endcase
  end

`ifdef ALU_MC_MUL_EN
  // sh_q doubles as the left-shifting multiplicand during MUL
  logic [WIDTH-1:0] acc_q, acc_d, mplier_q;
  assign acc_d = mplier_q[0] ? (acc_q + sh_q) : acc_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      sh_q        <= '0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      acc_q       <= '0;
      mplier_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q      <= op_e'(op);
            illegal_q <= 1'b0;
            if (comb_hit) begin
              result_q    <= comb_res;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else if (is_shift(op)) begin
              if (shamt == '0) begin
                result_q    <= a;
                out_valid_q <= 1'b1;
                state_q     <= S_DONE;
              end else begin
                sh_q    <= a;
                cnt_q   <= {1'b0, shamt};
                state_q <= S_SHIFT;
              end
`ifdef ALU_MC_MUL_EN
            end else if (op == OP_MUL) begin
              acc_q    <= '0;
              sh_q     <= a;
              mplier_q <= b;
              cnt_q    <= CNT_W'(WIDTH);
              state_q  <= S_MUL;
`endif
            end else begin
              result_q    <= '0;
              illegal_q   <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          sh_q  <= sh_d;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= sh_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`ifdef ALU_MC_MUL_EN
        S_MUL: begin
          acc_q    <= acc_d;
          sh_q     <= {sh_q[WIDTH-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
          cnt_q    <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            result_q    <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // Returning to IDLE costs a cycle, so no request is taken here
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: vector table plus back-pressure and reset sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a request at the negedge and return just after the accepting edge
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({name, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    bit seen;

    vt.push_back('{"add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1});
    vt.push_back('{"sub_wrap", 4'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0, 1});
    vt.push_back('{"and",      4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1});
    vt.push_back('{"or",       4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1});
    vt.push_back('{"xor",      4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1});
    vt.push_back('{"sll4",     4'd5, 32'h0000_0001, 32'h4,         32'h0000_0010, 1'b0, 5});
    vt.push_back('{"srl_ign",  4'd6, 32'h8000_0000, 32'h21,        32'h4000_0000, 1'b0, 2});
    vt.push_back('{"srl31",    4'd6, 32'h8000_0000, 32'h1F,        32'h0000_0001, 1'b0, 32});
    vt.push_back('{"sra31",    4'd7, 32'h8000_0000, 32'h1F,        32'hFFFF_FFFF, 1'b0, 32});
    vt.push_back('{"sra_zero", 4'd7, 32'h8000_0000, 32'h20,        32'h8000_0000, 1'b0, 1});
    vt.push_back('{"sra_pos",  4'd7, 32'h4000_0000, 32'h2,         32'h1000_0000, 1'b0, 3});
    vt.push_back('{"slt",      4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1});
    vt.push_back('{"sltu",     4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1});
    vt.push_back('{"illegal",  4'd15, 32'h1234_5678, 32'h1,        32'h0,         1'b1, 1});
`ifdef ALU_MC_MUL_EN
    vt.push_back('{"mul",      4'd10, 32'h7,        32'h6,         32'd42,        1'b0, 33});
    vt.push_back('{"mul_wrap", 4'd10, 32'hFFFF_FFFF, 32'h3,        32'hFFFF_FFFD, 1'b0, 33});
`else
    vt.push_back('{"mul_off",  4'd10, 32'h7,        32'h6,         32'h0,         1'b1, 1});
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result",    result,         32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      wait_out(lat);
      chk({vt[i].name, "_lat"}, 32'(lat), 32'(vt[i].lat));
      chk({vt[i].name, "_res"}, result, vt[i].res);
      chk({vt[i].name, "_ill"}, 32'(illegal), 32'(vt[i].ill));
      release_out(vt[i].name);
    end

    // Back-pressure: result held, new requests ignored, no accept in DONE
    issue(4'd0, 32'd3, 32'd4);
    wait_out(lat);
    chk("bp_lat", 32'(lat), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      op = 4'd1; a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_result",   result,          32'd7);
      chk("bp_in_ready", 32'(in_ready),   32'd0);
      chk("bp_valid",    32'(out_valid),  32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_hs_in_ready",  32'(in_ready),  32'd1);
    chk("bp_hs_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(out_valid), 32'd0);

    // Reset mid-shift aborts the operation
    issue(4'd5, 32'd1, 32'd20);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_result",   result,        32'd0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    issue(4'd0, 32'd1, 32'd1);
    wait_out(lat);
    chk("post_abort_lat", 32'(lat), 32'd1);
    chk("post_abort_res", result,   32'd2);
    release_out("post_abort");

    // Reset dominates a simultaneous request
    @(negedge clk);
    rst = 1'b1; op = 4'd0; a = 32'd5; b = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drop_valid", 32'(out_valid), 32'd0);
    chk("rst_drop_ready", 32'(in_ready),  32'd1);

    // Reset in DONE clears the illegal flag and result
    issue(4'd12, 32'hDEAD_BEEF, 32'h1);
    wait_out(lat);
    chk("ill_done_flag", 32'(illegal), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ill_rst_flag",  32'(illegal),   32'd0);
    chk("ill_rst_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
